// File: rtl/weight_bram_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_bram_reader_if
// Description : Bundle of the layer-control, BRAM-port and consumer signals
//               of the weight BRAM reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_bram_reader_if #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int WEIGHT_WIDTH       = 32
);
  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr;
  logic [BRAM_ADDRESS_WIDTH-1:0] addr_limit;
  logic                          address_reset;
  logic                          bram_control_add1;
  logic                          bram_control_add2;
  logic                          bram_port_sel;
  logic                          load_weight_preload;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_a_addr;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_b_addr;
  logic                          bram_en;
  logic [WEIGHT_WIDTH-1:0]       bram_a_dout;
  logic [WEIGHT_WIDTH-1:0]       bram_b_dout;
  logic                          weight_from_bram_valid;
  logic [WEIGHT_WIDTH-1:0]       preload_data;
  logic [15:0]                   fetch_cnt;

  // Controller / environment side
  modport master (
    output base_addr, addr_limit, address_reset, bram_control_add1,
           bram_control_add2, bram_port_sel, load_weight_preload,
           bram_a_dout, bram_b_dout,
    input  bram_a_addr, bram_b_addr, bram_en, weight_from_bram_valid,
           preload_data, fetch_cnt
  );

  // Reader side
  modport slave (
    input  base_addr, addr_limit, address_reset, bram_control_add1,
           bram_control_add2, bram_port_sel, load_weight_preload,
           bram_a_dout, bram_b_dout,
    output bram_a_addr, bram_b_addr, bram_en, weight_from_bram_valid,
           preload_data, fetch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/weight_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : weight_bram_reader
// Description : Walks a circular weight window [base_addr, addr_limit] in a
//               dual-port BRAM, waits out the read latency after every
//               pointer move and captures words for the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bram_reader #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int WEIGHT_WIDTH       = 32,
  parameter int READ_LATENCY       = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  weight_bram_reader_if.slave  bus
);

  localparam int         AW         = BRAM_ADDRESS_WIDTH;
  localparam int         SUM_W      = BRAM_ADDRESS_WIDTH + 2;
  localparam logic [2:0] LAT_RELOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                  state;
  logic [AW-1:0]           ptr;
  logic [2:0]              lat_cnt;
  logic                    en_r;
  logic                    valid_r;
  logic [WEIGHT_WIDTH-1:0] preload_r;
  logic [15:0]             fetch_cnt_r;

  logic [1:0]              inc;
  logic [SUM_W-1:0]        sum;
  logic [SUM_W-1:0]        limit_ext;
  logic [SUM_W-1:0]        overshoot;
  logic [AW-1:0]           stepped_ptr;
  logic                    update;
  logic [AW-1:0]           update_ptr;

  // Next pointer: step of 0..3 with wrap back into the window; the extra two
  // bits keep ptr+inc from overflowing before it is compared to the limit.
  always_comb begin
    inc         = {bus.bram_control_add2, bus.bram_control_add1};
    sum         = SUM_W'(ptr) + SUM_W'(inc);
    limit_ext   = SUM_W'(bus.addr_limit);
    overshoot   = sum - limit_ext - SUM_W'(1);
    stepped_ptr = (sum > limit_ext) ? (bus.base_addr + overshoot[AW-1:0])
                                    : sum[AW-1:0];
    update      = bus.address_reset | (inc != 2'b00);
    update_ptr  = bus.address_reset ? bus.base_addr : stepped_ptr;
  end

  // Port B reads the word after port A, wrapping at the end of the window.
  always_comb begin
    bus.bram_a_addr            = ptr;
    bus.bram_b_addr            = (ptr == bus.addr_limit) ? bus.base_addr
                                                         : ptr + AW'(1);
    bus.bram_en                = en_r;
    bus.weight_from_bram_valid = valid_r;
    bus.preload_data           = preload_r;
    bus.fetch_cnt              = fetch_cnt_r;
  end

  // Fetch state machine, pointer, latency counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      lat_cnt     <= '0;
      en_r        <= 1'b0;
      valid_r     <= 1'b0;
      preload_r   <= '0;
      fetch_cnt_r <= '0;
    end else begin
      // Capture happens in any state; a load outside VALID is the
      // consumer's protocol error, not something the reader blocks.
      if (bus.load_weight_preload) begin
        preload_r <= bus.bram_port_sel ? bus.bram_b_dout : bus.bram_a_dout;
      end

      case (state)
        IDLE: begin
          // Stepping is meaningless until a layer window has been loaded.
          if (bus.address_reset) begin
            state       <= FETCH;
            ptr         <= bus.base_addr;
            lat_cnt     <= LAT_RELOAD;
            en_r        <= 1'b1;
            valid_r     <= 1'b0;
            fetch_cnt_r <= '0;
          end
        end

        FETCH: begin
          if (update) begin
            ptr     <= update_ptr;
            lat_cnt <= LAT_RELOAD;
            if (bus.address_reset) begin
              fetch_cnt_r <= '0;
            end
          end else if (lat_cnt == 3'd0) begin
            state   <= VALID;
            valid_r <= 1'b1;
            if (fetch_cnt_r != 16'hFFFF) begin
              fetch_cnt_r <= fetch_cnt_r + 16'd1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        VALID: begin
          if (update) begin
            state   <= FETCH;
            valid_r <= 1'b0;
            ptr     <= update_ptr;
            lat_cnt <= LAT_RELOAD;
            if (bus.address_reset) begin
              fetch_cnt_r <= '0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          en_r    <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_bram_reader
// Description : Directed, table-driven bench for weight_bram_reader with
//               hand-written sequences for wrap, latency restart and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_bram_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  weight_bram_reader_if #(.BRAM_ADDRESS_WIDTH(12), .WEIGHT_WIDTH(32)) bus ();

  weight_bram_reader #(
    .BRAM_ADDRESS_WIDTH(12),
    .WEIGHT_WIDTH      (32),
    .READ_LATENCY      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ar, a1, a2, ld, sel;
    logic [11:0] ea, eb;
    logic        een, ev;
    logic [31:0] ep;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[16];

  // Flag consumer loads that happen while no stable word is presented.
  always @(posedge clk) begin
    if (!rst && bus.load_weight_preload && !bus.weight_from_bram_valid)
      $display("note: protocol violation, preload while not valid at %0t", $time);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic a1, input logic a2,
                       input logic ld, input logic sel);
    bus.address_reset       = ar;
    bus.bram_control_add1   = a1;
    bus.bram_control_add2   = a2;
    bus.load_weight_preload = ld;
    bus.bram_port_sel       = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the window and step with add2 until ptr sits at 0x1FE.
  task automatic go_1fe();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 127; k++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("walk ptr", 32'(bus.bram_a_addr), 32'h1FE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    //            ar    a1    a2    ld    sel   ea       eb       en    v     pre            cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b0, 32'h0,        16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b0, 32'h0,        16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b1, 32'h0,        16'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b1, 32'h0,        16'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100, 12'h101, 1'b1, 1'b1, 32'h12345678, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b1, 32'h12345678, 16'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h100, 12'h101, 1'b1, 1'b1, 32'hAAAA5555, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h102, 12'h103, 1'b1, 1'b0, 32'hAAAA5555, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h102, 12'h103, 1'b1, 1'b0, 32'hAAAA5555, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h102, 12'h103, 1'b1, 1'b1, 32'hAAAA5555, 16'd2};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h103, 12'h104, 1'b1, 1'b0, 32'hAAAA5555, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h103, 12'h104, 1'b1, 1'b0, 32'hAAAA5555, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h103, 12'h104, 1'b1, 1'b1, 32'hAAAA5555, 16'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b0, 32'hAAAA5555, 16'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b0, 32'hAAAA5555, 16'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h101, 1'b1, 1'b1, 32'hAAAA5555, 16'd1};

    bus.base_addr   = 12'h100;
    bus.addr_limit  = 12'h1FF;
    bus.bram_a_dout = 32'hAAAA5555;
    bus.bram_b_dout = 32'h12345678;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #2;
    check("reset a_addr",  32'(bus.bram_a_addr), 32'h0);
    check("reset en",      32'(bus.bram_en), 32'h0);
    check("reset valid",   32'(bus.weight_from_bram_valid), 32'h0);
    check("reset preload", bus.preload_data, 32'h0);
    check("reset cnt",     32'(bus.fetch_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #4;

    // Table: load window, latency, preload capture/hold, add2, add1, reload
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ar, vecs[i].a1, vecs[i].a2, vecs[i].ld, vecs[i].sel);
      tick();
      check($sformatf("v%0d a_addr", i),  32'(bus.bram_a_addr), 32'(vecs[i].ea));
      check($sformatf("v%0d b_addr", i),  32'(bus.bram_b_addr), 32'(vecs[i].eb));
      check($sformatf("v%0d en", i),      32'(bus.bram_en), 32'(vecs[i].een));
      check($sformatf("v%0d valid", i),   32'(bus.weight_from_bram_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d preload", i), bus.preload_data, vecs[i].ep);
      check($sformatf("v%0d cnt", i),     32'(bus.fetch_cnt), 32'(vecs[i].ec));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Latency restart: add1 on the first FETCH cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("restart ar valid", 32'(bus.weight_from_bram_valid), 32'h0);
    check("restart ar cnt",   32'(bus.fetch_cnt), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart ptr",    32'(bus.bram_a_addr), 32'h101);
    check("restart valid0", 32'(bus.weight_from_bram_valid), 32'h0);
    tick();
    check("restart valid1", 32'(bus.weight_from_bram_valid), 32'h0);
    tick();
    check("restart valid2", 32'(bus.weight_from_bram_valid), 32'h1);
    check("restart cnt",    32'(bus.fetch_cnt), 32'h1);
    tick();
    check("restart cnt hold", 32'(bus.fetch_cnt), 32'h1);

    // Wrap with add1+add2 from 0x1FE
    go_1fe();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap3 a_addr", 32'(bus.bram_a_addr), 32'h101);
    check("wrap3 b_addr", 32'(bus.bram_b_addr), 32'h102);

    // Port B wraps at the window end
    go_1fe();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("end a_addr", 32'(bus.bram_a_addr), 32'h1FF);
    check("end b_addr", 32'(bus.bram_b_addr), 32'h100);
    tick();
    tick();
    check("end valid", 32'(bus.weight_from_bram_valid), 32'h1);

    // Asynchronous reset in VALID
    #2;
    rst = 1'b1;
    #1;
    check("async a_addr",  32'(bus.bram_a_addr), 32'h0);
    check("async en",      32'(bus.bram_en), 32'h0);
    check("async valid",   32'(bus.weight_from_bram_valid), 32'h0);
    check("async preload", bus.preload_data, 32'h0);
    check("async cnt",     32'(bus.fetch_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // add1 in IDLE is ignored; preload still captures
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("idle ptr",     32'(bus.bram_a_addr), 32'h0);
    check("idle en",      32'(bus.bram_en), 32'h0);
    check("idle preload", bus.preload_data, 32'h12345678);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle ptr2", 32'(bus.bram_a_addr), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rearm a_addr", 32'(bus.bram_a_addr), 32'h100);
    check("rearm en",     32'(bus.bram_en), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_bram_reader.md
WEIGHT_BRAM_READER -- requirements
Module: weight_bram_reader

Interface
REQ-001 SHALL have parameter BRAM_ADDRESS_WIDTH, default 12, word address width of the weight BRAM.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 32, BRAM read data width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, BRAM read latency in cycles; legal range 1..7.
REQ-004 clk  input  1  the only clock; every register samples on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 base_addr  input  BRAM_ADDRESS_WIDTH  first weight address of the current layer.
REQ-007 addr_limit  input  BRAM_ADDRESS_WIDTH  last valid weight address of the current layer, inclusive.
REQ-008 address_reset  input  1  reload the pointer from base_addr.
REQ-009 bram_control_add1  input  1  advance the pointer by 1.
REQ-010 bram_control_add2  input  1  advance the pointer by 2.
REQ-011 bram_port_sel  input  1  output data select: 0 = port A, 1 = port B.
REQ-012 load_weight_preload  input  1  the consumer is taking preload_data this cycle.
REQ-013 bram_a_addr, bram_b_addr  output  BRAM_ADDRESS_WIDTH each  read addresses.
REQ-014 bram_en  output  1  read enable, common to both ports.
REQ-015 bram_a_dout, bram_b_dout  input  WEIGHT_WIDTH each  BRAM read data.
REQ-016 weight_from_bram_valid  output  1  the BRAM data at the current pointer is stable.
REQ-017 preload_data  output  WEIGHT_WIDTH  the last weight word captured by the consumer.
REQ-018 fetch_cnt  output  16  number of completed fetches since the last address_reset.

Function
REQ-019 The pointer ptr SHALL drive bram_a_addr = ptr; bram_b_addr = ptr+1 wraps to base_addr when ptr == addr_limit.
REQ-020 Pointer update priority:
- address_reset: ptr <= base_addr.
- otherwise, increment inc = 1*add1 + 2*add2, so both asserted gives 3.
REQ-021 Pointer wrap: if ptr+inc > addr_limit, ptr <= base_addr + (ptr+inc-addr_limit-1); the arithmetic SHALL be at BRAM_ADDRESS_WIDTH+2 bits.
- The wrapped result is undefined if it still exceeds addr_limit.
REQ-022 The state machine SHALL have the states IDLE, FETCH and VALID.
REQ-023 Transitions out of IDLE:
- IDLE->FETCH on address_reset.
- add1/add2 in IDLE are ignored: ptr is unchanged.
REQ-024 Entering FETCH SHALL load lat_cnt <= READ_LATENCY-1.
REQ-025 Behaviour in FETCH:
- lat_cnt decrements each cycle.
- FETCH->VALID when lat_cnt==0 and no pointer update occurs that cycle.
REQ-026 Behaviour in VALID:
- VALID->FETCH on any pointer update (address_reset, add1 or add2).
- Otherwise the block stays in VALID.
REQ-027 A pointer update in FETCH SHALL restart the latency count: lat_cnt <= READ_LATENCY-1.
REQ-028 bram_en SHALL be 1 in FETCH and VALID, and 0 in IDLE.
REQ-029 weight_from_bram_valid SHALL be registered: it is 1 exactly while the state is VALID.
- It drops on the cycle after the pointer update that leaves VALID.
REQ-030 While load_weight_preload is 1, preload_data SHALL capture (bram_port_sel ? bram_b_dout : bram_a_dout) on that edge.
- Otherwise preload_data holds its value.
REQ-031 A load_weight_preload outside VALID SHALL still capture; this is a protocol violation that the bench flags.
REQ-032 fetch_cnt counting:
- increments on each FETCH->VALID transition and saturates at 16'hFFFF.
- address_reset clears it to 0; on the same cycle, the clear takes priority.

Reset
REQ-033 While rst is high, and on its rising edge without waiting for clk, the following SHALL hold:
- state IDLE, ptr 0, lat_cnt 0.
- bram_en 0, weight_from_bram_valid 0.
- preload_data 0, fetch_cnt 0.
REQ-034 Reset mid-FETCH or mid-VALID SHALL abandon the fetch; after rst falls, the block waits in IDLE for address_reset.

Verification
REQ-035 base_addr=0x100, addr_limit=0x1FF, pulse address_reset -> bram_a_addr=0x100 and bram_b_addr=0x101 next cycle; valid=1 exactly 2 cycles after FETCH entry; fetch_cnt=1.
REQ-036 In VALID at ptr=0x100, pulse add2 -> valid 0 for 2 cycles; ptr=0x102; valid returns to 1.
REQ-037 ptr=0x1FE with add1 and add2 asserted together -> ptr=0x101 (wrap); at ptr=0x1FF, bram_b_addr=0x100.
REQ-038 In VALID with bram_a_dout=0xAAAA5555 and bram_b_dout=0x12345678, pulse load_weight_preload with port_sel=1 -> preload_data=0x12345678; drop the preload -> the value holds.
REQ-039 add1 on the first FETCH cycle -> the latency restarts; valid asserts 2 cycles after the add1 cycle; fetch_cnt increments only once.
REQ-040 Assert rst asynchronously while in VALID -> all outputs 0 immediately; add1 after release -> no change until address_reset.
